// File: rtl/pse_pkg.sv
// Shared types and constants for the pattern scan engine.
// The state enum is shared so the engine and anything probing it agree on the encoding.
package pse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_PAT,
      SCAN,
      DRAIN,
      WR_CTB,
      WR_CTO,
      WR_CTS,
      DONE
   } pse_state_t;

   localparam int DEF_PAT_ADDR = 32;
   localparam int DEF_RES_ADDR = 33;
   localparam int WIN          = 5;

endpackage

// File: rtl/pse_byte_match.sv
// Counts 5-bit pattern hits for one string byte.
// Hits are split into windows inside the byte and windows that straddle the previous byte.
module pse_byte_match
   import pse_pkg::*;
(
   input  logic [WIN-1:0] pat,
   input  logic [3:0]     prev_nib,
   input  logic [7:0]     cur,
   input  logic           first,
   output logic [2:0]     in_cnt,
   output logic           hit,
   output logic [2:0]     cross_cnt
);

   // Bits 11:8 hold the previous byte's low nibble. Windows starting at offsets
   // 0..3 lie inside cur; offsets 4..7 reach back across the byte boundary.
   logic [11:0] win_bits;

   assign win_bits = {prev_nib, cur};

   always_comb begin
      in_cnt    = 3'd0;
      cross_cnt = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (win_bits[i +: WIN] == pat) begin
            in_cnt = in_cnt + 3'd1;
         end
      end
      for (int i = 4; i < 8; i++) begin
         if (win_bits[i +: WIN] == pat) begin
            cross_cnt = cross_cnt + 3'd1;
         end
      end
      if (first) begin
         cross_cnt = 3'd0;
      end
   end

   assign hit = (in_cnt != 3'd0);

endmodule

// File: rtl/pattern_scan_engine.sv
// Bit-pattern search coprocessor: reads the pattern and string from data memory,
// counts in-byte, per-byte and whole-string hits, then writes the three counts back.
module pattern_scan_engine
   import pse_pkg::*;
#(
   parameter int NUM_BYTES = 32,
   parameter int STR_BASE  = 0,
   parameter int PAT_ADDR  = DEF_PAT_ADDR,
   parameter int RES_ADDR  = DEF_RES_ADDR,
   parameter int AW        = 8
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   output logic          Done,
   output logic [AW-1:0] MemAddr,
   input  logic [7:0]    MemRdData,
   output logic          MemWrEn,
   output logic [7:0]    MemWrData
);

   localparam int            KW     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NUM_BYTES - 1);
   localparam logic [AW-1:0] STR_A  = AW'(STR_BASE);
   localparam logic [AW-1:0] PAT_A  = AW'(PAT_ADDR);
   localparam logic [AW-1:0] RES_A  = AW'(RES_ADDR);

   pse_state_t     state_q;
   logic [KW-1:0]  k_q;
   logic [WIN-1:0] pat_q;
   logic [3:0]     prev_q;
   logic [7:0]     ctb_q, cto_q, cts_q;
   logic [7:0]     ctb_d, cto_d, cts_d;
   logic           done_q, wren_q;
   logic [AW-1:0]  addr_q;
   logic [7:0]     wdata_q;

   logic           acc_en;
   logic           first_byte;
   logic [2:0]     in_cnt;
   logic           hit;
   logic [2:0]     cross_cnt;

   // Read data lags the address by one cycle, so SCAN step k sees byte k-1
   // (step 0 sees the pattern byte) and DRAIN sees the final byte.
   assign acc_en     = ((state_q == SCAN) && (k_q != '0)) || (state_q == DRAIN);
   assign first_byte = (state_q == SCAN) && (k_q == KW'(1));

   pse_byte_match u_match (
      .pat       (pat_q),
      .prev_nib  (prev_q),
      .cur       (MemRdData),
      .first     (first_byte),
      .in_cnt    (in_cnt),
      .hit       (hit),
      .cross_cnt (cross_cnt)
   );

   always_comb begin
      ctb_d = ctb_q;
      cto_d = cto_q;
      cts_d = cts_q;
      if (acc_en) begin
         ctb_d = ctb_q + {5'd0, in_cnt};
         cto_d = cto_q + {7'd0, hit};
         cts_d = cts_q + {5'd0, in_cnt} + {5'd0, cross_cnt};
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         pat_q   <= '0;
         prev_q  <= '0;
         ctb_q   <= '0;
         cto_q   <= '0;
         cts_q   <= '0;
         done_q  <= 1'b0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         ctb_q <= ctb_d;
         cto_q <= cto_d;
         cts_q <= cts_d;
         if (acc_en) begin
            prev_q <= MemRdData[3:0];
         end
         case (state_q)
            IDLE, DONE: begin
               if (Start) begin
                  state_q <= LOAD_PAT;
                  addr_q  <= PAT_A;
                  done_q  <= 1'b0;
                  ctb_q   <= '0;
                  cto_q   <= '0;
                  cts_q   <= '0;
                  prev_q  <= '0;
               end
            end
            LOAD_PAT: begin
               state_q <= SCAN;
               k_q     <= '0;
               addr_q  <= STR_A;
            end
            SCAN: begin
               if (k_q == '0) begin
                  pat_q <= MemRdData[7:3];
               end
               if (k_q == K_LAST) begin
                  state_q <= DRAIN;
               end else begin
                  k_q    <= k_q + 1'b1;
                  addr_q <= STR_A + AW'(k_q + 1'b1);
               end
            end
            DRAIN: begin
               // ctb_d already includes the last byte, which lands this cycle.
               state_q <= WR_CTB;
               wren_q  <= 1'b1;
               addr_q  <= RES_A;
               wdata_q <= ctb_d;
            end
            WR_CTB: begin
               state_q <= WR_CTO;
               addr_q  <= RES_A + AW'(1);
               wdata_q <= cto_q;
            end
            WR_CTO: begin
               state_q <= WR_CTS;
               addr_q  <= RES_A + AW'(2);
               wdata_q <= cts_q;
            end
            WR_CTS: begin
               state_q <= DONE;
               wren_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Done      = done_q;
   assign MemAddr   = addr_q;
   assign MemWrEn   = wren_q;
   assign MemWrData = wdata_q;

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Bench for pattern_scan_engine: fixed vector table, hand-built corner sequences,
// and random scans compared with a whole-string reference model.
module tb_pattern_scan_engine;

   localparam int NB      = 32;
   localparam int LATENCY = NB + 6;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       Start = 1'b0;
   logic       Done;
   logic [7:0] MemAddr;
   logic [7:0] MemRdData;
   logic       MemWrEn;
   logic [7:0] MemWrData;

   logic [7:0] mem [0:255];
   int         checks = 0;
   int         failures = 0;
   int         wr_cnt = 0;

   typedef struct {
      logic [7:0] pat_byte;
      logic [7:0] b_even;
      logic [7:0] b_odd;
      int         e_ctb;
      int         e_cto;
      int         e_cts;
   } vec_t;

   vec_t vecs [4];

   pattern_scan_engine dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Done      (Done),
      .MemAddr   (MemAddr),
      .MemRdData (MemRdData),
      .MemWrEn   (MemWrEn),
      .MemWrData (MemWrData)
   );

   // clock and data memory (synchronous read, one-cycle latency)
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      MemRdData <= mem[MemAddr];
      if (MemWrEn) begin
         mem[MemAddr] <= MemWrData;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic fill_alt(input logic [7:0] pat_byte, input logic [7:0] be, input logic [7:0] bo);
      mem[32] = pat_byte;
      for (int i = 0; i < NB; i++) mem[i] = (i % 2 == 0) ? be : bo;
   endtask

   task automatic fill_rand();
      mem[32] = 8'($urandom_range(0, 255));
      for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
   endtask

   // Reference: treat the string as one 256-bit vector, byte 0 most significant.
   task automatic golden(output int ctb, output int cto, output int cts);
      logic [255:0] s;
      logic [4:0]   p;
      logic [7:0]   b;
      int           nin;
      p   = mem[32][7:3];
      ctb = 0;
      cto = 0;
      cts = 0;
      for (int i = 0; i < NB; i++) s[255 - 8*i -: 8] = mem[i];
      for (int j = 0; j <= 251; j++) if (s[j +: 5] == p) cts++;
      for (int i = 0; i < NB; i++) begin
         b   = mem[i];
         nin = 0;
         for (int o = 0; o < 4; o++) if (b[o +: 5] == p) nin++;
         ctb += nin;
         if (nin != 0) cto++;
      end
   endtask

   // Pulse Start so edge 0 samples it; cycle c ends at edge c, so Done is
   // expected first visible just after edge LATENCY-1.
   task automatic run_scan(input string tag, input int repulse_at);
      int lat;
      wr_cnt = 0;
      @(negedge Clk);
      Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      chk({tag, "_done_low_after_start"}, int'(Done), 0);
      lat = -1;
      for (int e = 1; e <= 100; e++) begin
         @(posedge Clk);
         #1;
         Start = (e == repulse_at);
         if (Done) begin
            lat = e + 1;
            break;
         end
      end
      Start = 1'b0;
      chk({tag, "_latency"}, lat, LATENCY);
      chk({tag, "_write_count"}, wr_cnt, 3);
   endtask

   task automatic check_results(input string tag, input int ctb, input int cto, input int cts);
      chk({tag, "_ctb"}, int'(mem[33]), ctb);
      chk({tag, "_cto"}, int'(mem[34]), cto);
      chk({tag, "_cts"}, int'(mem[35]), cts);
   endtask

   initial begin
      int ectb, ecto, ects;

      vecs[0] = '{8'b10101_000, 8'h55, 8'h55, 64, 32, 126};
      vecs[1] = '{8'b00000_000, 8'h00, 8'h00, 128, 32, 252};
      vecs[2] = '{8'b11111_000, 8'h03, 8'hE0, 0, 0, 16};
      vecs[3] = '{8'b11111_000, 8'h00, 8'h00, 0, 0, 0};

      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));

      // reset state
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_done", int'(Done), 0);
      chk("reset_wren", int'(MemWrEn), 0);
      chk("reset_addr", int'(MemAddr), 0);
      chk("reset_wdata", int'(MemWrData), 0);
      Reset = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("idle_done", int'(Done), 0);
      chk("idle_wren", int'(MemWrEn), 0);

      // fixed vector table
      for (int v = 0; v < 4; v++) begin
         fill_alt(vecs[v].pat_byte, vecs[v].b_even, vecs[v].b_odd);
         run_scan($sformatf("vec%0d", v), 0);
         check_results($sformatf("vec%0d", v), vecs[v].e_ctb, vecs[v].e_cto, vecs[v].e_cts);
      end

      // Start re-pulsed mid-scan must not disturb the run or add a result set
      fill_rand();
      golden(ectb, ecto, ects);
      run_scan("repulse", 15);
      check_results("repulse", ectb, ecto, ects);
      repeat (10) @(posedge Clk);
      #1;
      chk("repulse_no_extra_writes", wr_cnt, 3);
      chk("repulse_done_held", int'(Done), 1);

      // restart from DONE with new data
      fill_rand();
      golden(ectb, ecto, ects);
      run_scan("restart", 0);
      check_results("restart", ectb, ecto, ects);

      // reset during SCAN at k=10: no writes, sentinels survive
      mem[33] = 8'hA5;
      mem[34] = 8'h5A;
      mem[35] = 8'h3C;
      fill_rand();
      wr_cnt = 0;
      @(negedge Clk);
      Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
      repeat (11) @(posedge Clk);
      #1 Reset = 1'b1;
      @(posedge Clk);
      #1;
      chk("midreset_done", int'(Done), 0);
      chk("midreset_wren", int'(MemWrEn), 0);
      Reset = 1'b0;
      repeat (45) @(posedge Clk);
      #1;
      chk("midreset_no_writes", wr_cnt, 0);
      chk("midreset_done_idle", int'(Done), 0);
      chk("midreset_mem33", int'(mem[33]), 8'hA5);
      chk("midreset_mem34", int'(mem[34]), 8'h5A);
      chk("midreset_mem35", int'(mem[35]), 8'h3C);
      golden(ectb, ecto, ects);
      run_scan("after_reset", 0);
      check_results("after_reset", ectb, ecto, ects);

      // randomized scans against the reference model
      for (int r = 0; r < 100; r++) begin
         fill_rand();
         golden(ectb, ecto, ects);
         run_scan($sformatf("rand%0d", r), 0);
         check_results($sformatf("rand%0d", r), ectb, ecto, ects);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
